// File: rtl/pend_enc_pkg.sv
// Shared types for the pending-mask encoder: mask/index widths and FSM states.
package pend_enc_pkg;

  localparam int WIDTH = 32;
  localparam int IDX_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] mask_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc32.sv
// Combinational 32-to-5 priority encoder with "any" and "exactly one" flags.
// PENC_MSB_FIRST_EN: when defined, the highest set bit wins instead of the lowest.
module prio_enc32
  import pend_enc_pkg::*;
(
  input  mask_t i_mask,
  output idx_t  o_idx,
  output logic  o_any,
  output logic  o_single
);

  // Winning index; the last assignment in loop order has priority.
  always_comb begin
    o_idx = '0;
`ifdef PENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (i_mask[i]) o_idx = idx_t'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = idx_t'(i);
    end
`endif
  end

  // Clearing the lowest set bit leaves zero only for a one-hot mask.
  assign o_any    = |i_mask;
  assign o_single = o_any && ((i_mask & (i_mask - mask_t'(1))) == '0);

endmodule

// File: rtl/pend_enc32.sv
// Sequential 32-to-5 encoder: walks a multi-hot pending mask and emits one
// set-bit index per valid/ready handshake.
// PENC_MSB_FIRST_EN (via prio_enc32): emit indices highest first.
//
// state | meaning
// IDLE  | load_ready=1, waiting for a mask; a zero mask only pulses done
// DRAIN | out_valid=1, presenting the priority bit of r_mask until it is empty
module pend_enc32
  import pend_enc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_valid,
  output logic  load_ready,
  input  mask_t load_mask,
  output logic  out_valid,
  input  logic  out_ready,
  output idx_t  out_idx,
  output logic  out_last,
  input  logic  abort,
  output logic  done
);

  state_t r_state, w_next_state;
  mask_t  r_mask,  w_next_mask;
  logic   r_done,  w_next_done;
  logic   w_any, w_single;

  prio_enc32 u_prio (
    .i_mask   (r_mask),
    .o_idx    (out_idx),
    .o_any    (w_any),
    .o_single (w_single)
  );

  // Outputs depend on the registered state and mask only, never on out_ready.
  assign load_ready = (r_state == IDLE);
  assign out_valid  = (r_state == DRAIN) && w_any;
  assign out_last   = (r_state == DRAIN) && w_single;
  assign done       = r_done;

  // State, pending mask and the registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_mask  <= w_next_mask;
      r_done  <= w_next_done;
    end
  end

  // Next state: abort dominates any load or handshake in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_mask  = r_mask;
    w_next_done  = 1'b0;
    if (abort) begin
      w_next_state = IDLE;
      w_next_mask  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            if (|load_mask) begin
              w_next_mask  = load_mask;
              w_next_state = DRAIN;
            end else begin
              w_next_done = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            w_next_mask[out_idx] = 1'b0;
            if (w_single) begin
              w_next_state = IDLE;
              w_next_done  = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_mask  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pend_enc32.sv
// Self-checking bench for pend_enc32: table of directed masks, abort/reset
// corner sequences, then random masks with random out_ready against a
// queue-based reference of the expected index order.
module tb_pend_enc32;
  import pend_enc_pkg::*;

  logic  clk = 1'b0;
  logic  reset, load_valid, load_ready, out_valid, out_ready, out_last, abort, done;
  mask_t load_mask;
  idx_t  out_idx;

  int errs = 0;
  int checks = 0;

  pend_enc32 dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_mask  (load_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .abort      (abort),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference order: every set bit of the mask, in emission priority order.
  task automatic build_order(input mask_t m, output int q[$]);
    q = {};
    for (int i = 0; i < WIDTH; i++) begin
`ifdef PENC_MSB_FIRST_EN
      if (m[WIDTH-1-i]) q.push_back(WIDTH - 1 - i);
`else
      if (m[i]) q.push_back(i);
`endif
    end
  endtask

  // Load a mask and drain it. Entry/exit point: 1 time unit after a rising edge.
  // mode 0: out_ready always 1; 1: toggles 1,0,1,0; 2: random.
  task automatic drain_mask(input mask_t m, input int mode,
                            output int n, output int first, output int lastv);
    int   q[$];
    int   cyc;
    logic rdy;
    build_order(m, q);
    n = 0; first = -1; lastv = -1;
    chk("load_ready_before_load", load_ready, 1);
    load_valid = 1'b1;
    load_mask  = m;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_mask  = $urandom;
    if (q.size() == 0) begin
      chk("zero_mask_no_valid", out_valid, 0);
      chk("zero_mask_done", done, 1);
      chk("zero_mask_load_ready", load_ready, 1);
      return;
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      #4;
      chk("drain_valid", out_valid, 1);
      chk("drain_idx", out_idx, q[0]);
      chk("drain_last", out_last, (q.size() == 1));
      chk("drain_done_low", done, 0);
      chk("drain_load_ready_low", load_ready, 0);
      if (rdy) begin
        if (n == 0) first = int'(out_idx);
        if (out_last) lastv = int'(out_idx);
        n++;
        void'(q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (q.size() != 0) chk("drain_timeout_remaining", q.size(), 0);
    out_ready = 1'b0;
    chk("end_valid_low", out_valid, 0);
    chk("end_done_pulse", done, 1);
    chk("end_load_ready_with_done", load_ready, 1);
  endtask

  typedef struct {
    mask_t mask;
    int    mode;
    int    cnt;
    int    lo;
    int    hi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int    n, first, lastv;
    int    exp_first, exp_last;
    mask_t m;

    vecs[0] = '{32'h0000_0029, 0, 3,  0,  5};
    vecs[1] = '{32'h8000_0000, 0, 1, 31, 31};
    vecs[2] = '{32'hFFFF_FFFF, 1, 32, 0, 31};
    vecs[3] = '{32'h0000_0000, 0, 0,  0,  0};
    vecs[4] = '{32'h0000_0001, 0, 1,  0,  0};
    vecs[5] = '{32'h0000_00F0, 2, 4,  4,  7};

    reset = 1'b1; load_valid = 1'b0; load_mask = '0; out_ready = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_load_ready", load_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table; each drain starts in the done cycle of the previous one.
    for (int v = 0; v < 6; v++) begin
`ifdef PENC_MSB_FIRST_EN
      exp_first = vecs[v].hi; exp_last = vecs[v].lo;
`else
      exp_first = vecs[v].lo; exp_last = vecs[v].hi;
`endif
      drain_mask(vecs[v].mask, vecs[v].mode, n, first, lastv);
      chk("table_count", n, vecs[v].cnt);
      if (vecs[v].cnt > 0) begin
        chk("table_first_idx", first, exp_first);
        chk("table_last_idx", lastv, exp_last);
      end
    end
    @(posedge clk); #1;
    chk("done_one_cycle_only", done, 0);

    // Abort together with the second handshake of 0xF0.
    load_valid = 1'b1; load_mask = 32'h0000_00F0;
    @(posedge clk); #1;
    load_valid = 1'b0; out_ready = 1'b1;
    #4;
`ifdef PENC_MSB_FIRST_EN
    chk("abort_first_idx", out_idx, 7);
`else
    chk("abort_first_idx", out_idx, 4);
`endif
    @(posedge clk); #1;
    abort = 1'b1;
    #4;
`ifdef PENC_MSB_FIRST_EN
    chk("abort_second_idx", out_idx, 6);
`else
    chk("abort_second_idx", out_idx, 5);
`endif
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    #4;
    chk("abort_valid_low", out_valid, 0);
    chk("abort_no_done", done, 0);
    chk("abort_idle", load_ready, 1);
    @(posedge clk); #1;
    chk("abort_no_done_later", done, 0);
    chk("abort_stays_idle", out_valid, 0);

    // Abort beats a simultaneous load.
    abort = 1'b1; load_valid = 1'b1; load_mask = 32'h0000_00FF;
    @(posedge clk); #1;
    abort = 1'b0; load_valid = 1'b0;
    chk("abort_load_rejected_valid", out_valid, 0);
    chk("abort_load_rejected_done", done, 0);
    chk("abort_load_rejected_ready", load_ready, 1);
    drain_mask(32'h0000_0003, 0, n, first, lastv);
    chk("after_abort_count", n, 2);

    // Asynchronous reset in the middle of a drain.
    @(posedge clk); #1;
    load_valid = 1'b1; load_mask = 32'h0000_00F0;
    @(posedge clk); #1;
    load_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("reset_mid_valid", out_valid, 0);
    chk("reset_mid_ready", load_ready, 1);
    chk("reset_mid_last", out_last, 0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b0;
    #4;
    chk("reset_mid_no_done", done, 0);
    @(posedge clk); #1;
    chk("reset_mid_no_done_later", done, 0);
    chk("reset_mid_idle", out_valid, 0);
    drain_mask(32'h0000_0029, 0, n, first, lastv);
    chk("after_reset_count", n, 3);

    // Random masks with random backpressure.
    for (int r = 0; r < 30; r++) begin
      m = (r % 7 == 3) ? '0 : mask_t'($urandom & $urandom);
      drain_mask(m, 2, n, first, lastv);
      chk("random_count", n, $countones(m));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pend_enc32.md
Name: pend_enc32

Overview:
- Sequential 32-to-5 encoder: the inverse of the register-file write-select decoder.
- Accepts a 32-bit multi-hot pending mask, e.g. a scoreboard or flush mask of architectural registers.
- Emits the 5-bit index of each set bit, one per handshake, lowest index first.
- Used by the pipeline's writeback/flush sequencer to walk pending registers.

Parameters:
- WIDTH, 32, mask width; fixed by the package, not overridden per instance.
- IDX_W, 5, index width, equal to $clog2(WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  a mask is offered.
- load_ready  out  1  block is idle and can accept a mask.
- load_mask  in  WIDTH  multi-hot mask to encode.
- out_valid  out  1  out_idx holds a valid index.
- out_ready  in  1  consumer accepts out_idx.
- out_idx  out  IDX_W  index of the current lowest remaining set bit.
- out_last  out  1  the current index is the final one of this mask.
- abort  in  1  synchronous flush of any in-progress mask.
- done  out  1  one-cycle pulse after a mask is fully drained.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state=IDLE, mask_q=0, out_valid=0, out_idx=0, out_last=0, done=0. load_ready=1 while in IDLE, including during reset.
- States: IDLE and DRAIN.
- IDLE:
  - load_ready=1, out_valid=0.
  - Load fires on load_valid & load_ready.
  - Load with a nonzero mask: mask_q<=load_mask, go to DRAIN.
  - Load with load_mask==0: stay in IDLE, done=1 on the next cycle, no out_valid ever.
- DRAIN:
  - load_ready=0; load_valid is ignored and the mask is not sampled.
  - out_valid=1.
  - out_idx = index of the lowest set bit of mask_q.
  - out_last=1 iff exactly one bit of mask_q is set.
  - out_idx and out_last are combinational from mask_q only. They must not depend on out_ready.
- Latency: a load accepted at edge N gives out_valid=1 with the first index valid right after edge N (cycle N+1). No bubble.
- Handshake in DRAIN:
  - On out_valid & out_ready, clear bit out_idx of mask_q.
  - If out_last, go to IDLE and pulse done=1 in the following cycle.
  - Otherwise the next index appears in the following cycle.
  - With out_ready=0, out_idx and out_last hold stable. The standard valid/ready rule applies: the block never drops out_valid without a handshake, except on abort or reset.
  - Throughput: one index per cycle while out_ready=1.
- abort:
  - In any state, on the next edge: mask_q<=0, state=IDLE, no done pulse.
  - abort wins over a simultaneous out handshake and over a simultaneous load; the load is not accepted.
- Reset mid-DRAIN drops everything immediately (asynchronous); no done pulse.
- Boundaries:
  - Bit 31 only: a single output, idx=31, last=1.
  - All 32 bits set: 32 outputs, idx 0..31, last=1 only on 31.
  - done and load_ready=1 coincide in the first IDLE cycle, so a new load may be accepted in the same cycle done is high.

Optional Feature:
- Macro: PENC_MSB_FIRST_EN.
- Defined: priority is inverted. out_idx = highest set bit, so indices are emitted 31 down to 0. All handshake, out_last and done behaviour is unchanged.
- Undefined: lowest-index-first order as specified above.

Decomposition:
- Package pend_enc_pkg holds:
  - WIDTH=32 and IDX_W=5.
  - typedef logic [WIDTH-1:0] mask_t.
  - typedef logic [IDX_W-1:0] idx_t.
  - enum state_t {IDLE, DRAIN}.
- One sub-module, prio_enc32: combinational 32-to-5 priority encoder.
  - Inputs: mask_t.
  - Outputs: idx_t, any (some bit set), single (exactly one bit set).
  - Honors PENC_MSB_FIRST_EN.
- The top level holds only the state register, mask_q and the handshake logic.

Test Plan:
- Reset then load 0x0000_0029 with out_ready=1 -> idx 0,3,5 on consecutive cycles; last=1 only with 5; done pulses one cycle after idx 5; load_ready=1 again.
- Load 0x8000_0000 -> single output idx=31, last=1; done next cycle.
- Load 0xFFFF_FFFF, out_ready toggled 1,0,1,0 -> idx holds while ready=0; 32 handshakes total in ascending order; last only on 31.
- Load 0x0000_0000 -> out_valid never rises; done=1 on the next cycle.
- Load 0x0000_00F0, abort asserted together with the second handshake (idx 5) -> state IDLE next cycle; idx 6 and 7 never emitted; no done; a new load is accepted afterwards. Repeat with reset asserted mid-DRAIN -> same outcome: no done, block idle.
- With PENC_MSB_FIRST_EN defined, load 0x0000_0029 -> idx 5,3,0; last on 0.
